unroller: RTL
=============

// Module: unroller
// PURPOSE
//   Deserializer; the inverse of roller. Collects IN_SIZE-element beats from a
//   narrow valid/ready stream and packs NUM/IN_SIZE consecutive beats into one
//   NUM-element parallel vector. Sits between a narrow producer (e.g. fixed_relu
//   at IN_0_SIZE=1) and a wide consumer (linear layer with larger IN_0_SIZE).
//   Double-buffered (fill buffer + output register), so it sustains 1 beat/cycle.
// PARAMETERS
//   DATA_WIDTH  32  bits per element
//   NUM         8   elements per output vector; NUM % IN_SIZE == 0 (elab $error otherwise)
//   IN_SIZE     2   elements per input beat; BEATS = NUM/IN_SIZE; CNT_W = max(1,$clog2(BEATS))
// PORTS
//   clk             in   1                  clock, rising edge
//   rst             in   1                  synchronous reset, active-high
//   data_in         in   DATA_WIDTH x IN_SIZE  input beat, unpacked array [IN_SIZE-1:0]
//   data_in_valid   in   1                  input beat valid
//   data_in_ready   out  1                  input beat accepted when valid&&ready
//   data_out        out  DATA_WIDTH x NUM   packed vector, unpacked array [NUM-1:0]
//   data_out_valid  out  1                  output vector valid
//   data_out_ready  in   1                  downstream accepts when valid&&ready
// BEHAVIOUR
// - Reset (sync, active-high): beat counter=0, fill buffer=0, data_out=0 (all
//   elements), data_out_valid=0. data_in_ready=0 while rst is high.
// - Ordering: beat k (k=0..BEATS-1, arrival order) fills data_out[k*IN_SIZE +: IN_SIZE];
//   data_in[i] -> element k*IN_SIZE+i. Matches roller's emission order (lowest first).
// - States: count = number of beats held in fill buffer (0..BEATS-1).
//   FILL (count<BEATS-1): accept beat, write slot count, count++.
//   LAST (count==BEATS-1): accepting beat completes vector -> output register
//   loads {fill buffer, data_in} in one cycle, data_out_valid<=1, count<=0.
// - data_in_ready (combinational, no dependence on data_in_valid):
//   = !rst && !(count==BEATS-1 && data_out_valid && !data_out_ready).
//   I.e. only the completing beat stalls, and only while the output slot is
//   occupied and not being drained this cycle.
// - Output: data_out/data_out_valid registered. Cleared valid on valid&&ready
//   unless a new vector loads the same cycle (then stays 1 with new data).
//   data_out stable while valid && !ready (AXI-stream hold rule).
// - Latency: data_out_valid rises the cycle after the last beat of a vector is
//   accepted. Throughput: 1 input beat/cycle when data_out_ready held high.
// - BEATS==1 (IN_SIZE==NUM): degenerates to a full-throughput register slice.
// - Simultaneous output drain + completing beat: both occur, no bubble.
// - data_in_valid low mid-vector: count holds, partial buffer retained
//   indefinitely; no timeout.
// - Reset mid-vector: partial beats discarded, pending output dropped.
// - Fill buffer contents beyond count are don't-care for verification;
//   only data_out while data_out_valid is checked.
// - Arithmetic: none; pure data movement, no width change.
// TESTING
// 1 Reset: rst=1 two cycles with data_in_valid=1 -> data_in_ready=0,
//   data_out_valid=0, data_out all 0; no beat counted after release.
// 2 Basic pack (NUM=8,IN_SIZE=2): beats {1,2},{3,4},{5,6},{7,8} back-to-back,
//   data_out_ready=1 -> one cycle after beat 4, data_out=[1..8] index 0..7, valid 1 cycle.
// 3 Streaming: 16 consecutive beats (values 0..31), ready=1 -> 4 vectors, no
//   input stall, data_in_ready constantly 1.
// 4 Backpressure: data_out_ready=0 after vector A; send 4 more beats -> beats
//   1-3 accepted, beat 4 stalls (ready=0), data_out holds A; raise ready ->
//   A drained and beat 4 accepted same cycle, vector B valid next cycle.
// 5 Input gaps + mid-reset: send 2 beats, idle 5 cycles, assert rst 1 cycle,
//   send 4 fresh beats {9..16} -> single vector [9..16]; pre-reset beats absent.
// 6 BEATS==1 (IN_SIZE=NUM=4): random valid/ready for 1000 cycles -> output
//   sequence equals input sequence, no loss/duplication (scoreboard).

Source files
------------

// File: rtl/unroller.sv
// Packs NUM/IN_SIZE narrow beats into one NUM-element vector; output registered one cycle after the last beat.
// Only the completing beat backpressures, and only while the output register is full and not draining.
module unroller #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM        = 8,
  parameter int IN_SIZE    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_SIZE-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int BEATS = NUM / IN_SIZE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (NUM % IN_SIZE != 0) begin : g_bad_size
      $error("unroller: NUM must be a multiple of IN_SIZE");
    end
  endgenerate

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q [NUM-1:0];
  logic [DATA_WIDTH-1:0] fill_d [NUM-1:0];
  logic [DATA_WIDTH-1:0] out_q  [NUM-1:0];
  logic [DATA_WIDTH-1:0] out_d  [NUM-1:0];
  logic                  out_vld_q, out_vld_d;
  logic                  is_last;
  logic                  accept;

  assign is_last       = (cnt_q == LAST_CNT);
  assign data_in_ready = !rst && !(is_last && out_vld_q && !data_out_ready);
  assign accept        = data_in_valid && data_in_ready;

  always_comb begin
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (out_vld_q && data_out_ready) begin
      out_vld_d = 1'b0;
    end
    if (accept) begin
      for (int k = 0; k < BEATS; k++) begin
        for (int i = 0; i < IN_SIZE; i++) begin
          if (cnt_q == CNT_W'(k)) begin
            fill_d[k*IN_SIZE + i] = data_in[i];
          end
        end
      end
      // The completing beat goes straight into the output register via fill_d.
      if (is_last) begin
        cnt_d     = '0;
        out_d     = fill_d;
        out_vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      fill_q    <= '{default: '0};
      out_q     <= '{default: '0};
      out_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = out_vld_q;

endmodule
